// File: rtl/fc_score_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc_score_collector_pkg
// Brief  : Shared defaults, FSM state type, per-class bias table and
//          saturation limits for the FC score collector.
// Rev    : 1.0
// ============================================================================
package fc_score_collector_pkg;

  localparam int NUM_CLS_DEF = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W       = 4;
  localparam int BIAS_TBL_N  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } fc_state_t;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  // Table is sized for the largest class count o_count can represent.
  localparam logic signed [DATA_W_DEF-1:0] CLS_BIAS [BIAS_TBL_N] = '{
    32'sd1, -32'sd1, 32'sd2, -32'sd2, 32'sd3, -32'sd3, 32'sd4, -32'sd4,
    32'sd5, -32'sd5, 32'sd0,  32'sd0, 32'sd0,  32'sd0, 32'sd0,  32'sd0
  };

endpackage
`default_nettype wire

// File: rtl/fc_score_collector_sat_add.sv
`default_nettype none
// ============================================================================
// Module : fc_score_collector_sat_add
// Brief  : Signed W-bit adder clamping to the signed W-bit min/max.
// Rev    : 1.0
// ============================================================================
module fc_score_collector_sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum
);

  localparam logic signed [W-1:0] C_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] C_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] w_wide;

  assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

  // Overflow shows as disagreement between the extra sign bit and the MSB.
  always_comb begin
    o_sum = w_wide[W-1:0];
    if (w_wide[W] != w_wide[W-1]) begin
      o_sum = w_wide[W] ? C_MIN : C_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc_score_collector.sv
`default_nettype none
// ============================================================================
// Module : fc_score_collector
// Brief  : Gathers NUM_CLS signed score beats into a vector for argmax;
//          define FC_SCORE_BIAS_EN to add a saturating per-class bias.
// Rev    : 1.0
// ============================================================================
module fc_score_collector
  import fc_score_collector_pkg::*;
#(
  parameter int NUM_CLS = NUM_CLS_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_valid,
  input  logic                     i_last,
  input  logic                     i_clear,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_data [NUM_CLS],
  output logic                     o_valid,
  output logic                     o_frame_err,
  output logic [CNT_W-1:0]         o_count
);

  fc_state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_count, w_count_nxt;
  logic                    r_err, w_err_nxt;
  logic                    w_acc, w_final, w_wr_shadow, w_load_out;
  logic signed [DATA_W-1:0] w_beat;
  logic signed [DATA_W-1:0] r_shadow [NUM_CLS];
  logic signed [DATA_W-1:0] r_out    [NUM_CLS];

  assign o_ready     = (r_state != ST_EMIT);
  assign w_acc       = i_valid && o_ready;
  assign w_final     = (r_count == CNT_W'(NUM_CLS - 1));
  assign o_valid     = (r_state == ST_EMIT) && !i_clear;
  assign o_frame_err = r_err && !i_clear;
  assign o_count     = r_count;
  assign o_data      = r_out;

`ifdef FC_SCORE_BIAS_EN
  logic signed [DATA_W-1:0] w_bias;

  always_comb begin
    w_bias = '0;
    for (int k = 0; k < NUM_CLS; k++) begin
      if (r_count == CNT_W'(k)) w_bias = CLS_BIAS[k][DATA_W-1:0];
    end
  end

  fc_score_collector_sat_add #(.W(DATA_W)) u_sat_add (
    .i_a   (i_data),
    .i_b   (w_bias),
    .o_sum (w_beat)
  );
`else
  assign w_beat = i_data;
`endif

  // IDLE is simply COLLECT at count 0, so both share one transition rule.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
    w_wr_shadow = 1'b0;
    w_load_out  = 1'b0;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_acc) begin
            if (i_last && w_final) begin
              w_load_out  = 1'b1;
              w_state_nxt = ST_EMIT;
              w_count_nxt = r_count + CNT_W'(1);
            end else if (i_last) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_IDLE;
              w_count_nxt = '0;
            end else if (w_final) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_DRAIN;
              w_count_nxt = r_count + CNT_W'(1);
            end else begin
              w_wr_shadow = 1'b1;
              w_state_nxt = ST_COLLECT;
              w_count_nxt = r_count + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
        ST_DRAIN: begin
          if (w_acc && i_last) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < NUM_CLS; k++) begin
        r_shadow[k] <= '0;
        r_out[k]    <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      // The final beat bypasses the shadow so the output loads in one step.
      for (int k = 0; k < NUM_CLS; k++) begin
        if (w_wr_shadow && (r_count == CNT_W'(k))) r_shadow[k] <= w_beat;
        if (w_load_out) r_out[k] <= (k == NUM_CLS - 1) ? w_beat : r_shadow[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_score_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_score_collector
// Brief  : Directed and random frames against a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_fc_score_collector;
  import fc_score_collector_pkg::*;

  localparam int NCLS = NUM_CLS_DEF;
  localparam int DW   = DATA_W_DEF;
  localparam int VW   = NCLS * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst     = 1'b1;
  logic signed [DW-1:0] i_data  = '0;
  logic                 i_valid = 1'b0;
  logic                 i_last  = 1'b0;
  logic                 i_clear = 1'b0;
  logic                 o_ready, o_valid, o_frame_err;
  logic signed [DW-1:0] o_data [NCLS];
  logic [CNT_W-1:0]     o_count;

  fc_score_collector #(.NUM_CLS(NCLS), .DATA_W(DW)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .i_clear     (i_clear),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_count     (o_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stored value of class k for a raw beat d.
  function automatic logic signed [DW-1:0] scored(input logic signed [DW-1:0] d, input int k);
    longint s;
    if (k >= NCLS) $error("class index %0d out of range", k);
`ifdef FC_SCORE_BIAS_EN
    s = longint'(d) + longint'(CLS_BIAS[k]);
`else
    s = longint'(d);
`endif
    if (s > longint'(SAT_MAX)) return SAT_MAX;
    if (s < longint'(SAT_MIN)) return SAT_MIN;
    return DW'(s);
  endfunction

  // Reference model: frame-level bookkeeping, evaluated mid-cycle.
  int                   cyc = 0;
  logic signed [DW-1:0] m_out [NCLS];
  logic signed [DW-1:0] frame [$];
  bit                   drain;
  int                   m_cnt, emit_at, err_at;
  logic [VW-1:0]        dut_flat, mdl_flat;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    dut_flat = '0;
    mdl_flat = '0;
    for (int k = 0; k < NCLS; k++) begin
      dut_flat[k*DW +: DW] = o_data[k];
      mdl_flat[k*DW +: DW] = m_out[k];
    end
  end

  always @(negedge clk) begin : p_model
    logic exp_ready, exp_valid, exp_err;
    if (rst) begin
      for (int k = 0; k < NCLS; k++) m_out[k] = '0;
      frame.delete();
      drain   = 1'b0;
      m_cnt   = 0;
      emit_at = -1;
      err_at  = -1;
    end else begin
      exp_ready = (emit_at != cyc);
      exp_valid = (emit_at == cyc) && !i_clear;
      exp_err   = (err_at == cyc) && !i_clear;
      check("ready", VW'(o_ready), VW'(exp_ready));
      check("valid", VW'(o_valid), VW'(exp_valid));
      check("frame_err", VW'(o_frame_err), VW'(exp_err));
      check("count", VW'(o_count), VW'(m_cnt));
      check("data", dut_flat, mdl_flat);
      if (emit_at == cyc) m_cnt = 0;
      if (i_clear) begin
        frame.delete();
        drain = 1'b0;
        m_cnt = 0;
      end else if (i_valid && exp_ready) begin
        if (drain) begin
          if (i_last) begin
            drain = 1'b0;
            m_cnt = 0;
          end
        end else begin
          frame.push_back(scored(i_data, frame.size()));
          if (i_last && frame.size() == NCLS) begin
            for (int k = 0; k < NCLS; k++) m_out[k] = frame[k];
            emit_at = cyc + 1;
            m_cnt   = NCLS;
            frame.delete();
          end else if (i_last) begin
            err_at = cyc + 1;
            m_cnt  = 0;
            frame.delete();
          end else if (frame.size() == NCLS) begin
            err_at = cyc + 1;
            drain  = 1'b1;
            m_cnt  = NCLS;
            frame.delete();
          end else begin
            m_cnt = frame.size();
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    i_valid = 1'b0;
    i_data  = DW'($urandom);
    i_last  = 1'($urandom % 2);
    i_clear = ($urandom % 20) == 0;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    while (!o_ready && guard < 4) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 4) check("ready_timeout", VW'(o_ready), VW'(1));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  initial begin
    int len, r;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_count", VW'(o_count), VW'(0));
    check("rst_valid", VW'(o_valid), VW'(0));

    // Basic frame 1..10 back-to-back.
    for (int b = 0; b < NCLS; b++) beat(DW'(b + 1), b == NCLS - 1);
    check("basic_valid", VW'(o_valid), VW'(1));
    for (int k = 0; k < NCLS; k++) check("basic_data", VW'($unsigned(o_data[k])), VW'($unsigned(scored(DW'(k + 1), k))));
    idle(1);
    check("basic_count0", VW'(o_count), VW'(0));
    check("basic_onepulse", VW'(o_valid), VW'(0));

    // Short frame.
    for (int b = 0; b < 6; b++) beat(DW'(100 + b), b == 5);
    check("short_err", VW'(o_frame_err), VW'(1));
    check("short_novalid", VW'(o_valid), VW'(0));
    check("short_keep", VW'($unsigned(o_data[0])), VW'($unsigned(scored(DW'(1), 0))));
    for (int b = 0; b < NCLS; b++) beat(DW'(20 + b), b == NCLS - 1);
    check("after_short_valid", VW'(o_valid), VW'(1));

    // Long frame of 13 beats.
    for (int b = 0; b < 13; b++) begin
      beat(DW'(200 + b), b == 12);
      if (b == NCLS - 1) check("long_err", VW'(o_frame_err), VW'(1));
      if (b == 12) check("long_noerr2", VW'(o_frame_err), VW'(0));
    end
    for (int b = 0; b < NCLS; b++) beat(DW'(40 + b), b == NCLS - 1);
    check("after_long_valid", VW'(o_valid), VW'(1));
    check("after_long_d9", VW'($unsigned(o_data[NCLS-1])), VW'($unsigned(scored(DW'(49), NCLS - 1))));

    // Clear coincident with the final beat.
    for (int b = 0; b < NCLS - 1; b++) beat(DW'(60 + b), 1'b0);
    i_clear = 1'b1;
    beat(DW'(69), 1'b1);
    i_clear = 1'b0;
    check("clear_novalid", VW'(o_valid), VW'(0));
    check("clear_count", VW'(o_count), VW'(0));
    idle(1);
    check("clear_novalid2", VW'(o_valid), VW'(0));
    for (int b = 0; b < NCLS; b++) beat(DW'(b - 10), b == NCLS - 1);
    check("neg_valid", VW'(o_valid), VW'(1));
    for (int k = 0; k < NCLS; k++) check("neg_data", VW'($unsigned(o_data[k])), VW'($unsigned(scored(DW'(k - 10), k))));

`ifdef FC_SCORE_BIAS_EN
    beat(32'h7FFF_FFFF, 1'b0);
    beat(32'h8000_0000, 1'b0);
    for (int b = 2; b < NCLS; b++) beat('0, b == NCLS - 1);
    check("sat_hi", VW'($unsigned(o_data[0])), VW'(32'h7FFF_FFFF));
    check("sat_lo", VW'($unsigned(o_data[1])), VW'(32'h8000_0000));
`endif

    // Reset mid-frame discards the partial frame.
    for (int b = 0; b < 5; b++) beat(DW'(300 + b), 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    check("midrst_count", VW'(o_count), VW'(0));
    check("midrst_data", VW'($unsigned(o_data[0])), VW'(0));

    // Random frames: mostly good, some short and long, random clears in gaps.
    for (int f = 0; f < 100; f++) begin
      r = int'($urandom % 10);
      if (r < 6)      len = NCLS;
      else if (r < 8) len = int'($urandom_range(1, NCLS - 1));
      else            len = int'($urandom_range(NCLS + 1, NCLS + 4));
      for (int b = 0; b < len; b++) begin
        while ($urandom % 2) gap();
        beat(DW'($urandom), b == len - 1);
      end
    end

    idle(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
